// File: rtl/itcm_pkg.sv
// itcm_pkg: shared ISA widths and fetch packet types for the instruction TCM.
//   RV_PC_SIZE    - fetch byte-address width
//   RV_IR_SIZE    - instruction word width
//   RV_IR_ILLEGAL - word returned for fetches outside the memory window
//   fch_req_pkt_t - fetch request payload {pc}
//   fch_rsp_pkt_t - fetch response payload {ir}
package itcm_pkg;

    localparam int unsigned RV_PC_SIZE = 32;
    localparam int unsigned RV_IR_SIZE = 32;

    localparam logic [RV_IR_SIZE-1:0] RV_IR_ILLEGAL = 32'h0000_0000;

    typedef struct packed {
        logic [RV_PC_SIZE-1:0] pc;
    } fch_req_pkt_t;

    typedef struct packed {
        logic [RV_IR_SIZE-1:0] ir;
    } fch_rsp_pkt_t;

endpackage

// File: rtl/itcm_if.sv
// Fetch request / response handshake interfaces.
//   vld - payload valid (driven by master)
//   rdy - sink ready (driven by slave)
//   pkt - payload, held stable while vld & ~rdy
interface fch_req_if_t;
    logic                   vld;
    logic                   rdy;
    itcm_pkg::fch_req_pkt_t pkt;

    modport slv (input vld, input pkt, output rdy);
    modport mst (output vld, output pkt, input rdy);
endinterface

interface fch_rsp_if_t;
    logic                   vld;
    logic                   rdy;
    itcm_pkg::fch_rsp_pkt_t pkt;

    modport slv (input vld, input pkt, output rdy);
    modport mst (output vld, output pkt, input rdy);
endinterface

// File: rtl/itcm_sp_sram.sv
// sp_sram: single-port behavioural SRAM, one read or one write per cycle.
//   clk, rst_n - clock, async active-low reset (output pipeline only)
//   en, we     - access enable, write select
//   addr       - word index
//   wdata      - write data
//   rdata      - read data, valid RD_LAT cycles after a read access
module sp_sram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pipe_q [RD_LAT];
    logic [WIDTH-1:0] pipe_d [RD_LAT];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Stage 0 holds when idle; the consumer tracks validity separately.
    always_comb begin
        pipe_d[0] = (en && !we) ? mem[addr] : pipe_q[0];
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/itcm.sv
// itcm: instruction tightly-coupled memory feeding the fetch unit.
//   clk, rst_n   - clock, async active-low reset
//   fch_req_slv  - fetch request in (pc byte address)
//   fch_rsp_mst  - fetch response out (ir), in request order, full backpressure
//   ld_we        - load-port write enable (wins over fetch acceptance)
//   ld_addr      - load-port word index
//   ld_data      - load-port write data
module itcm
    import itcm_pkg::*;
#(
    parameter int unsigned           DEPTH     = 4096,
    parameter int unsigned           RD_LAT    = 1,
    parameter logic [RV_PC_SIZE-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fch_req_if_t.slv                 fch_req_slv,
    fch_rsp_if_t.mst                 fch_rsp_mst,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [RV_IR_SIZE-1:0]    ld_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FD = RD_LAT + 1;
    localparam int unsigned OW = $clog2(FD + 1);
    localparam int unsigned PW = $clog2(FD);
    localparam logic [RV_PC_SIZE-1:0] SPAN = RV_PC_SIZE'(DEPTH * 4);

    // Request side
    logic [RV_PC_SIZE-1:0] pc_off;
    logic                  req_oor;
    logic [AW-1:0]         rd_idx;
    logic                  req_rdy;
    logic                  req_hsk;

    // Read pipeline
    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [RD_LAT-1:0]     oor_q, oor_d;
    logic [RV_IR_SIZE-1:0] sram_rdata;
    logic                  last_vld;
    logic [RV_IR_SIZE-1:0] last_ir;

    // Response FIFO and occupancy
    logic [RV_IR_SIZE-1:0] fifo_q [FD];
    logic [RV_IR_SIZE-1:0] fifo_d [FD];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         fcnt_q, fcnt_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  rsp_vld;
    logic [RV_IR_SIZE-1:0] rsp_ir;
    logic                  rsp_hsk;

    // Offset wraps for pc < BASE_ADDR, so one unsigned compare covers both bounds.
    assign pc_off  = fch_req_slv.pkt.pc - BASE_ADDR;
    assign req_oor = (pc_off >= SPAN);
    assign rd_idx  = pc_off[AW+1:2];

    assign req_rdy = !ld_we && ((occ_q < OW'(FD)) || rsp_hsk);
    assign req_hsk = fch_req_slv.vld && req_rdy;

    sp_sram #(
        .DEPTH  (DEPTH),
        .WIDTH  (RV_IR_SIZE),
        .RD_LAT (RD_LAT)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ld_we || (req_hsk && !req_oor)),
        .we    (ld_we),
        .addr  (ld_we ? ld_addr : rd_idx),
        .wdata (ld_data),
        .rdata (sram_rdata)
    );

    always_comb begin
        vld_d    = vld_q;
        oor_d    = oor_q;
        vld_d[0] = req_hsk;
        oor_d[0] = req_hsk && req_oor;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            oor_d[i] = oor_q[i-1];
        end
    end

    assign last_vld = vld_q[RD_LAT-1];
    assign last_ir  = oor_q[RD_LAT-1] ? RV_IR_ILLEGAL : sram_rdata;

    // Bypass: with the FIFO empty the pipeline head drives the response
    // directly and is only captured if the consumer stalls. The occupancy
    // limit guarantees a free FIFO slot for every arriving read.
    assign fifo_empty = (fcnt_q == '0);
    assign rsp_vld    = !fifo_empty || last_vld;
    assign rsp_ir     = !fifo_empty ? fifo_q[rd_ptr_q] :
                        (last_vld   ? last_ir : '0);
    assign rsp_hsk    = rsp_vld && fch_rsp_mst.rdy;
    assign push       = last_vld && !(fifo_empty && fch_rsp_mst.rdy);
    assign pop        = !fifo_empty && fch_rsp_mst.rdy;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = last_ir;
            wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        fcnt_d = fcnt_q + OW'(push) - OW'(pop);
        occ_d  = occ_q + OW'(req_hsk) - OW'(rsp_hsk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            oor_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < FD; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            oor_q    <= oor_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            occ_q    <= occ_d;
            fifo_q   <= fifo_d;
        end
    end

    assign fch_req_slv.rdy    = req_rdy;
    assign fch_rsp_mst.vld    = rsp_vld;
    assign fch_rsp_mst.pkt.ir = rsp_ir;

endmodule

// File: tb/tb_itcm.sv
// tb_itcm: scoreboard bench for itcm (DEPTH=16, RD_LAT=2, BASE_ADDR=0).
module tb_itcm;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned FD     = RD_LAT + 1;

    typedef struct {
        logic [31:0] ir;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;

    fch_req_if_t req_if ();
    fch_rsp_if_t rsp_if ();

    itcm #(
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_req_slv (req_if),
        .fch_rsp_mst (rsp_if),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned n_acc    = 0;
    bit          chk_lat  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] pc);
        logic [3:0] idx;
        idx = pc[5:2];
        return (pc < 32'(DEPTH * 4)) ? ref_mem[idx] : 32'h0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] pc, output int unsigned waited);
        exp_t e;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = pc;
        waited        = 0;
        forever begin
            @(negedge clk);
            if (req_if.rdy) begin
                e.ir  = model(pc);
                e.cyc = cyc;
                exp_q.push_back(e);
                n_acc++;
                break;
            end
            waited++;
            if (waited > 50) begin
                check("req_timeout", waited, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_if.vld = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_we      = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    // Response monitor: scoreboard compare, latency, and stall stability.
    initial begin
        exp_t        e;
        bit          stall_seen = 0;
        logic [31:0] held_ir    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_seen) begin
                    check("hold_vld", {31'd0, rsp_if.vld}, 1);
                    check("hold_ir", rsp_if.pkt.ir, held_ir);
                end
                if (rsp_if.vld && rsp_if.rdy) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_rsp", {31'd0, rsp_if.vld}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_ir", rsp_if.pkt.ir, e.ir);
                        if (chk_lat) check("rsp_lat", cyc - e.cyc, RD_LAT);
                    end
                end
                stall_seen = rsp_if.vld && !rsp_if.rdy;
                held_ir    = rsp_if.pkt.ir;
            end else begin
                stall_seen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        logic [31:0] prog [4];
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113;
        prog[3] = 32'h0030_8193;

        rst_n         = 1'b0;
        ld_we         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        req_if.vld    = 1'b0;
        req_if.pkt.pc = '0;
        rsp_if.rdy    = 1'b0;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", {31'd0, req_if.rdy}, 1);
        check("rst_rsp_vld", {31'd0, rsp_if.vld}, 0);
        check("rst_rsp_ir", rsp_if.pkt.ir, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_vld", {31'd0, rsp_if.vld}, 0);
        end
        @(posedge clk);
        #1;

        // Program load
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 4) load(4'(i), prog[i]);
            else       load(4'(i), 32'hA000_0000 + 32'(i) * 32'h0000_0111);
        end

        // Back-to-back fetches, no backpressure
        rsp_if.rdy = 1'b1;
        chk_lat    = 1;
        for (int unsigned i = 0; i < 4; i++) begin
            send(32'(i * 4), w);
            check("b2b_wait", w, 0);
        end
        drain();
        chk_lat = 0;

        // Backpressure: consumer stalled for 6 cycles
        rsp_if.rdy = 1'b0;
        n_acc      = 0;
        fork
            begin
                for (int unsigned i = 0; i < 4; i++) send(32'(i * 4), w);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("bp_accepts", n_acc, FD);
                check("bp_req_rdy", {31'd0, req_if.rdy}, 0);
                @(posedge clk);
                #1;
                rsp_if.rdy = 1'b1;
            end
        join
        drain();

        // Out-of-range, wrap-around and misaligned fetches
        chk_lat = 1;
        send(32'd0, w);
        send(32'd64, w);
        send(32'd4, w);
        send(32'hFFFF_FFFC, w);
        send(32'd7, w);
        send(32'd60, w);
        drain();

        // Load collision: write and fetch of the same word
        ld_we         = 1'b1;
        ld_addr       = 4'd5;
        ld_data       = 32'hDEAD_BEEF;
        req_if.vld    = 1'b1;
        req_if.pkt.pc = 32'd20;
        @(negedge clk);
        check("coll_req_rdy", {31'd0, req_if.rdy}, 0);
        @(posedge clk);
        #1;
        ld_we      = 1'b0;
        ref_mem[5] = 32'hDEAD_BEEF;
        send(32'd20, w);
        check("coll_wait", w, 0);
        drain();

        // Reset with 2 in flight + 1 buffered
        chk_lat    = 0;
        rsp_if.rdy = 1'b0;
        send(32'd0, w);
        send(32'd4, w);
        send(32'd12, w);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy", {31'd0, req_if.rdy}, 1);
        check("mid_rst_vld", {31'd0, rsp_if.vld}, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rsp_if.rdy = 1'b1;
        rst_n      = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_vld", {31'd0, rsp_if.vld}, 0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1;
        send(32'd8, w);
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
